// File: rtl/gray_conv_arbiter.sv
// Shared binary<->Gray converter time-multiplexed between NumReq requesters by a
// round-robin arbiter; results return through one registered, id-tagged response port.
module gray_conv_arbiter #(
  parameter int NumReq  = 4,
  parameter int Width   = 9,
  parameter int IdWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  input  logic [NumReq-1:0]       req_op_i,
  input  logic [NumReq*Width-1:0] req_data_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [IdWidth-1:0]      rsp_id_o,
  output logic                    rsp_op_o,
  output logic [Width-1:0]        rsp_data_o
);

  logic [IdWidth-1:0] prio_reg;
  logic [IdWidth-1:0] prio_next;
  logic               rsp_valid_reg;
  logic [IdWidth-1:0] rsp_id_reg;
  logic               rsp_op_reg;
  logic [Width-1:0]   rsp_data_reg;

  logic [IdWidth-1:0] grant_id;
  logic               grant_any;
  logic               can_accept;
  logic               handshake;
  logic [Width-1:0]   data_arr [NumReq];
  logic [Width-1:0]   sel_data;
  logic               sel_op;
  logic [Width-1:0]   enc_data;
  logic [Width-1:0]   dec_data;
  logic [Width-1:0]   conv_data;

  // Index arithmetic modulo NumReq; works for non-power-of-two requester counts.
  function automatic logic [IdWidth-1:0] wrap_add(input logic [IdWidth-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NumReq) sum = sum - NumReq;
    return IdWidth'(sum);
  endfunction

  generate
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
      assign data_arr[gi] = req_data_i[gi*Width +: Width];
    end
  endgenerate

  // Scan from the farthest offset back toward prio_reg so the nearest valid requester wins.
  always_comb begin
    grant_id  = '0;
    grant_any = 1'b0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      if (req_valid_i[wrap_add(prio_reg, k)]) begin
        grant_any = 1'b1;
        grant_id  = wrap_add(prio_reg, k);
      end
    end
  end

  assign can_accept = !rsp_valid_reg || rsp_ready_i;
  assign handshake  = grant_any && can_accept && !rst_i;
  assign prio_next  = wrap_add(grant_id, 1);

  generate
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_ready
      assign req_ready_o[gi] = handshake && (grant_id == IdWidth'(gi));
    end
  endgenerate

  assign sel_data = data_arr[grant_id];
  assign sel_op   = req_op_i[grant_id];
  assign enc_data = sel_data ^ (sel_data >> 1);

  // Gray->binary: each binary bit is the XOR of all Gray bits at or above it.
  generate
    for (genvar gi = 0; gi < Width; gi++) begin : g_dec
      assign dec_data[gi] = ^sel_data[Width-1:gi];
    end
  endgenerate

  assign conv_data = sel_op ? dec_data : enc_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_reg      <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_op_reg    <= 1'b0;
      rsp_data_reg  <= '0;
    end else if (handshake) begin
      prio_reg      <= prio_next;
      rsp_valid_reg <= 1'b1;
      rsp_id_reg    <= grant_id;
      rsp_op_reg    <= sel_op;
      rsp_data_reg  <= conv_data;
    end else if (rsp_ready_i) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_id_o    = rsp_id_reg;
  assign rsp_op_o    = rsp_op_reg;
  assign rsp_data_o  = rsp_data_reg;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter: vector table, scoreboard monitor with arbiter model,
// and hand sequences for fairness, backpressure, round-trip sweep and mid-stream reset.
module tb_gray_conv_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [3:0]  req_op;
  logic [35:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic        rsp_op;
  logic [8:0]  rsp_data;

  int total = 0;
  int bad   = 0;

  gray_conv_arbiter #(.NumReq(4), .Width(9)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_op_o(rsp_op), .rsp_data_o(rsp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] ref_enc(input logic [8:0] b);
    return b ^ {1'b0, b[8:1]};
  endfunction

  function automatic logic [8:0] ref_dec(input logic [8:0] g);
    logic [8:0] b;
    b = g;
    for (int s = 1; s < 9; s = s * 2) b = b ^ (b >> s);
    return b;
  endfunction

  // Scoreboard: model grant/ready at negedge, push expected {id,op,data} on handshake.
  logic [11:0] sb_q[$];
  int          m_prio    = 0;
  bit          after_rst = 1'b0;

  always @(negedge clk) begin
    logic [3:0] er;
    logic       any;
    int         g;
    chk("rsp_valid", 32'(rsp_valid), 32'(sb_q.size() != 0));
    if (sb_q.size() != 0)
      chk("rsp_fields", 32'({rsp_id, rsp_op, rsp_data}), 32'(sb_q[0]));
    else if (after_rst)
      chk("rsp_zero_after_reset", 32'({rsp_id, rsp_op, rsp_data}), 32'd0);
    any = 1'b0;
    g   = 0;
    for (int k = 3; k >= 0; k--) begin
      if (req_valid[(m_prio + k) % 4]) begin
        any = 1'b1;
        g   = (m_prio + k) % 4;
      end
    end
    er = (!rst_i && any && (sb_q.size() == 0 || rsp_ready)) ? 4'(1 << g) : 4'd0;
    chk("req_ready", 32'(req_ready), 32'(er));
    if (rst_i) begin
      sb_q.delete();
      m_prio    = 0;
      after_rst = 1'b1;
    end else begin
      if (sb_q.size() != 0 && rsp_ready) void'(sb_q.pop_front());
      if (er != 4'd0) begin
        logic [8:0] d;
        d = req_data[g*9 +: 9];
        sb_q.push_back({2'(g), req_op[g], req_op[g] ? ref_dec(d) : ref_enc(d)});
        m_prio    = (g + 1) % 4;
        after_rst = 1'b0;
      end
    end
  end

  typedef struct {
    logic [3:0] valid;
    logic [3:0] op;
    logic [8:0] data;
    logic [3:0] exp_ready;
    logic       exp_v;
    logic [1:0] exp_id;
    logic       exp_op;
    logic [8:0] exp_data;
  } vec_t;

  vec_t tbl[9];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] code, prev_code;
    // each row: inputs for one cycle, expected ready now, expected response from the previous row
    tbl[0] = '{4'b0100, 4'b0000, 9'h0FF, 4'b0100, 1'b0, 2'd0, 1'b0, 9'h000};
    tbl[1] = '{4'b0010, 4'b0010, 9'h080, 4'b0010, 1'b1, 2'd2, 1'b0, 9'h080};
    tbl[2] = '{4'b0100, 4'b0000, 9'h1FF, 4'b0100, 1'b1, 2'd1, 1'b1, 9'h0FF};
    tbl[3] = '{4'b1000, 4'b0000, 9'h100, 4'b1000, 1'b1, 2'd2, 1'b0, 9'h100};
    tbl[4] = '{4'b0010, 4'b0010, 9'h100, 4'b0010, 1'b1, 2'd3, 1'b0, 9'h180};
    tbl[5] = '{4'b0000, 4'b0000, 9'h000, 4'b0000, 1'b1, 2'd1, 1'b1, 9'h1FF};
    tbl[6] = '{4'b0000, 4'b0000, 9'h000, 4'b0000, 1'b0, 2'd0, 1'b0, 9'h000};
    tbl[7] = '{4'b0001, 4'b0001, 9'h000, 4'b0001, 1'b0, 2'd0, 1'b0, 9'h000};
    tbl[8] = '{4'b0000, 4'b0000, 9'h000, 4'b0000, 1'b1, 2'd0, 1'b1, 9'h000};

    rst_i = 1'b1; req_valid = '0; req_op = '0; req_data = '0; rsp_ready = 1'b1;
    repeat (2) cyc();
    rst_i = 1'b0;

    for (int i = 0; i < 9; i++) begin
      req_valid = tbl[i].valid;
      req_op    = tbl[i].op;
      req_data  = {4{tbl[i].data}};
      rsp_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_valid", i), 32'(rsp_valid), 32'(tbl[i].exp_v));
      if (tbl[i].exp_v)
        chk($sformatf("tbl%0d_rsp", i), 32'({rsp_id, rsp_op, rsp_data}),
            32'({tbl[i].exp_id, tbl[i].exp_op, tbl[i].exp_data}));
      cyc();
    end

    // fairness: pointer sits at 1 after the table, so grants run 1,2,3,0,...
    req_valid = 4'b1111; req_op = 4'b0000;
    req_data  = {9'h0A5, 9'h03C, 9'h1C3, 9'h111};
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k > 0) chk($sformatf("fair_id%0d", k), 32'(rsp_id), 32'((1 + k - 1) % 4));
      cyc();
    end

    // backpressure: 12 grants from 1 leave the pointer at 1
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
      cyc();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_grant", 32'(req_ready), 32'b0010);
    cyc();
    req_valid = '0;
    repeat (2) cyc();

    // round-trip sweep through requester 0 (encode) and requester 3 (decode)
    prev_code = '0;
    for (int n = 0; n < 1024; n++) begin
      req_valid = 4'b0001; req_op = 4'b0000; req_data = '0;
      req_data[8:0] = 9'(n % 512);
      cyc();
      code = rsp_data;
      if (n > 0) chk($sformatf("sweep_onebit%0d", n), 32'($countones(code ^ prev_code)), 32'd1);
      prev_code = code;
      req_valid = 4'b1000; req_op = 4'b1000; req_data = '0;
      req_data[35:27] = code;
      cyc();
      chk($sformatf("sweep_rt%0d", n), 32'(rsp_data), 32'(n % 512));
    end
    req_valid = '0;
    cyc();

    // reset mid-stream with a pending response and all requesters valid
    req_valid = 4'b1111; req_op = 4'b0101; rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    cyc();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_outputs", 32'({rsp_id, rsp_op, rsp_data}), 32'd0);
    chk("rst_first_grant", 32'(req_ready), 32'b0001);
    cyc();
    req_valid = '0; rsp_ready = 1'b1;
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
